post_period_ctrl: RTL
=====================

POST_PERIOD_CTRL -- requirements
Module: post_period_ctrl

Interface
REQ-001 Parameter PERIOD_SEC, default 5: post-period length in seconds; legal 1..255.
REQ-002 Parameter TICK_DIV, default 100_000_000: Clk100M cycles per second; legal >= 2.
REQ-003 Parameter NUM_DIGITS, default 4: seven-segment digits driven; legal 1..8.
REQ-004 Parameter COUNT_W, default 8: magicSymbolCount width; legal 1..20.
REQ-005 Clk100M  in  1  sole clock; all state updates on its rising edge.
REQ-006 RstN  in  1  reset; synchronous, active-low.
REQ-007 postSig  in  1  start request; level or pulse, sampled only in IDLE.
REQ-008 abortSig  in  1  cancels a running period.
REQ-009 magicSymbolCount  in  COUNT_W  unsigned symbol count to display.
REQ-010 levelComplete  out  1  one-cycle pulse at the end of a full period.
REQ-011 busy  out  1  high while in RUN.
REQ-012 secondsLeft  out  8  remaining whole seconds.
REQ-013 postSeg  out  8*NUM_DIGITS  active-low segments; bits [8i+7:8i] = digit i; digit 0 least significant; bit 7 = dp, always 1.

Function
REQ-014 FSM states are IDLE, RUN and DONE; all outputs are registered.
REQ-015 IDLE with postSig=1: next state RUN; prescaler cleared; secondsLeft loaded with PERIOD_SEC; postSeg all 8'hFF until the first conversion lands.
REQ-016 RUN: prescaler counts 0..TICK_DIV-1 and wraps; at terminal count secondsLeft decrements by 1.
REQ-017 The decrement that reaches 0 moves the FSM to DONE; levelComplete is high in the cycle PERIOD_SEC*TICK_DIV+1 cycles after the cycle postSig was sampled.
REQ-018 DONE lasts exactly one cycle with levelComplete=1; it then returns to IDLE, and postSeg holds the last converted value.
REQ-019 postSig is ignored in RUN and DONE; no restart and no extension of the period.
REQ-020 abortSig=1 in RUN: next state IDLE, secondsLeft=0, postSeg=8'hFF, no levelComplete; abort beats a same-cycle terminal tick.
REQ-021 In RUN and DONE the converter restarts back-to-back on the current magicSymbolCount; each result loads postSeg atomically, with no mixed-digit frames.
REQ-022 Display latency is <= 2*(COUNT_W+2) cycles from a count change.
REQ-023 Leading zeros blank to 8'hFF; digit 0 always shows, so a value of 0 gives 8'hC0.
REQ-024 Values >= 10^NUM_DIGITS show 8'hBF (dash) on every digit.
REQ-025 Digit encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
REQ-026 Count changes are ignored while in IDLE.

Reset
REQ-027 RstN=0 at a rising edge forces: state IDLE, prescaler 0, converter idle, levelComplete 0, busy 0, secondsLeft 0, postSeg all 8'hFF.
REQ-028 Reset mid-RUN or mid-conversion produces no levelComplete and no partial display update.

Structure
REQ-029 Shared package post_pkg holds the state enum, SEG_BLANK, SEG_DASH and the digit-to-segment function.
REQ-030 Sub-module bin2bcd_seq is an iterative double-dabble with start/done handshake, COUNT_W+1 cycles per conversion, parametrised by COUNT_W and NUM_DIGITS.

Verification (TICK_DIV=4, PERIOD_SEC=3, NUM_DIGITS=4, COUNT_W=8 unless stated)
REQ-031 postSig pulse in cycle 0 -> busy from cycle 1; secondsLeft 2/1/0 from cycles 5/9/13; levelComplete high only in cycle 13.
REQ-032 Count 47 during RUN -> within 20 cycles postSeg = {FF,FF,99,F8}; count 0 -> {FF,FF,FF,C0}.
REQ-033 abortSig in cycle 6 -> IDLE in cycle 7, postSeg all FF, levelComplete never asserted.
REQ-034 postSig held high -> back-to-back periods with levelComplete pulses 14 cycles apart (cycles 13 and 27).
REQ-035 RstN low in cycle 7 of a run -> all outputs at reset values in cycle 8; no levelComplete.
REQ-036 NUM_DIGITS=2, count 200 -> postSeg = {BF,BF}.

Source files
------------

// File: rtl/post_pkg.sv
// Shared types and seven-segment helpers for the post-period controller.
// Segment bytes are active-low, with bit 7 as the decimal point.
package post_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one load cycle plus COUNT_W shift cycles.
// Results are valid with the one-cycle done_o pulse. ovf_o flags a value that does not fit in NUM_DIGITS digits.
module bin2bcd_seq
  import post_pkg::*;
#(
  parameter int COUNT_W    = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clr_i,
  input  logic                    start_i,
  input  logic [COUNT_W-1:0]      bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(COUNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_W - 1);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;

  // NOTE: every variable driven here gets a default before any branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    if (clr_i) begin
      busy_d = 1'b0;
    end else if (!busy_q && start_i) begin
      busy_d = 1'b1;
      ovf_d  = 1'b0;
      cnt_d  = '0;
      bin_d  = bin_i;
      bcd_d  = '0;
    end else if (busy_q) begin
      // The bit shifted out of the top digit is a carry into a digit the display lacks.
      ovf_d = ovf_q | adj[BCD_W-1];
      bcd_d = {adj[BCD_W-2:0], bin_q[COUNT_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: the datapath registers are reset as well, so the result registers never start out unknown.
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/post_period_ctrl.sv
// Post-period timer: counts PERIOD_SEC seconds down and pulses levelComplete at the end.
// Meanwhile it shows magicSymbolCount on active-low seven-segment digits.
module post_period_ctrl
  import post_pkg::*;
#(
  parameter int PERIOD_SEC = 5,
  parameter int TICK_DIV   = 100_000_000,
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_W    = 8
) (
  input  logic                    Clk100M,
  input  logic                    RstN,
  input  logic                    postSig,
  input  logic                    abortSig,
  input  logic [COUNT_W-1:0]      magicSymbolCount,
  output logic                    levelComplete,
  output logic                    busy,
  output logic [7:0]              secondsLeft,
  output logic [8*NUM_DIGITS-1:0] postSeg
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]      PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [8*NUM_DIGITS-1:0] SEG_ALL_BLANK = {NUM_DIGITS{SEG_BLANK}};

  state_e                  state_q, state_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [7:0]              secs_q, secs_d;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    busy_q, busy_d;
  logic                    lc_q, lc_d;

  logic                    tick;
  logic                    conv_start, conv_clr, conv_done, conv_ovf;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [8*NUM_DIGITS-1:0] fmt_seg;
  logic                    seen_nonzero;

  // The converter free-runs outside IDLE and is held cleared in IDLE, so stale results never reach the display.
  assign conv_start = (state_q != S_IDLE);
  assign conv_clr   = (state_q == S_IDLE);

  bin2bcd_seq #(
    .COUNT_W    (COUNT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk_i   (Clk100M),
    .rst_n_i (RstN),
    .clr_i   (conv_clr),
    .start_i (conv_start),
    .bin_i   (magicSymbolCount),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  // Leading-zero blanking runs from the top digit downward. Digit 0 is always lit.
  always_comb begin
    fmt_seg      = SEG_ALL_BLANK;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (conv_bcd[4*i +: 4] != 4'd0 || i == 0) seen_nonzero = 1'b1;
      fmt_seg[8*i +: 8] = seen_nonzero ? digit_to_seg(conv_bcd[4*i +: 4]) : SEG_BLANK;
    end
    if (conv_ovf) fmt_seg = {NUM_DIGITS{SEG_DASH}};
  end

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = '0;
    secs_d  = secs_q;
    seg_d   = seg_q;
    case (state_q)
      S_IDLE: begin
        if (postSig) begin
          state_d = S_RUN;
          secs_d  = 8'(PERIOD_SEC);
          seg_d   = SEG_ALL_BLANK;
        end
      end
      S_RUN: begin
        if (abortSig) begin
          state_d = S_IDLE;
          secs_d  = 8'd0;
          seg_d   = SEG_ALL_BLANK;
        end else begin
          presc_d = tick ? '0 : presc_q + PRESC_W'(1);
          if (conv_done) seg_d = fmt_seg;
          if (tick) begin
            secs_d = secs_q - 8'd1;
            if (secs_q == 8'd1) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (conv_done) seg_d = fmt_seg;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    lc_d   = (state_d == S_DONE);
  end

  always_ff @(posedge Clk100M) begin
    if (!RstN) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      secs_q  <= 8'd0;
      seg_q   <= SEG_ALL_BLANK;
      busy_q  <= 1'b0;
      lc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      secs_q  <= secs_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      lc_q    <= lc_d;
    end
  end

  assign levelComplete = lc_q;
  assign busy          = busy_q;
  assign secondsLeft   = secs_q;
  assign postSeg       = seg_q;

endmodule
